// File: rtl/regfile_pkg.sv
// Shared defaults and data-word type for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_NUM_RD = 2;

  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bundles the write port and packed read ports of regfile_mp into one interface.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = DEF_NUM_RD
) ();

  logic                       we;
  logic [ADDR_W-1:0]          waddr;
  logic [DATA_W-1:0]          wdata;
  logic [NUM_RD-1:0]          re;
  logic [NUM_RD*ADDR_W-1:0]   raddr;
  logic [NUM_RD*DATA_W-1:0]   rdata;
  logic [NUM_RD-1:0]          rvalid;

  modport master (
    output we, waddr, wdata, re, raddr,
    input  rdata, rvalid
  );

  modport slave (
    input  we, waddr, wdata, re, raddr,
    output rdata, rvalid
  );

endinterface

// File: rtl/regfile_read_mux.sv
// Combinational 2**ADDR_W-to-1 word selector; one instance per read port.
module regfile_read_mux
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [DATA_W-1:0] regs_i [1<<ADDR_W],
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = regs_i[addr_i];

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered read data and per-port valid.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0]        regs_q  [NREG];
  logic [DATA_W-1:0]        mux_out [NUM_RD];
  logic [DATA_W-1:0]        rd_d    [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rdata_q;
  logic [NUM_RD-1:0]        rvalid_q;
  logic                     wr_en;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_read_mux #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_mux (
      .regs_i(regs_q),
      .addr_i(raddr[g*ADDR_W +: ADDR_W]),
      .data_o(mux_out[g])
    );
  end

  always_comb begin
    wr_en = we && !((ZERO_REG != 0) && (waddr == '0));
  end

  // Zero-register forcing is applied last so it overrides any forwarded value.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_d[i] = mux_out[i];
`ifdef REGFILE_BYPASS_EN
      if (we && (raddr[i*ADDR_W +: ADDR_W] == waddr)) begin
        rd_d[i] = wdata;
      end
`endif
      if ((ZERO_REG != 0) && (raddr[i*ADDR_W +: ADDR_W] == '0)) begin
        rd_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[waddr] <= wdata;
      end
      rvalid_q <= re;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
        if (re[i]) begin
          rdata_q[i*DATA_W +: DATA_W] <= rd_d[i];
        end
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 2-port and a 3-port instance share clock and reset.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int unsigned DW = DEF_DATA_W;
  localparam int unsigned AW = DEF_ADDR_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2)) bus2 ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(3)) bus3 ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1)) dut2 (
    .clk(clk), .reset(reset), .we(bus2.we), .waddr(bus2.waddr), .wdata(bus2.wdata),
    .re(bus2.re), .raddr(bus2.raddr), .rdata(bus2.rdata), .rvalid(bus2.rvalid)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(3), .ZERO_REG(1)) dut3 (
    .clk(clk), .reset(reset), .we(bus3.we), .waddr(bus3.waddr), .wdata(bus3.wdata),
    .re(bus3.re), .raddr(bus3.raddr), .rdata(bus3.rdata), .rvalid(bus3.rvalid)
  );

  word_t sb_q[$];
  word_t mem2 [32];
  word_t mem3 [32];
  word_t last2 [2];
  word_t last3 [3];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic sb_pop(output word_t d);
    check_eq("sb_nonempty", 96'(sb_q.size() != 0), 96'd1);
    if (sb_q.size() != 0) d = sb_q.pop_front();
    else d = '0;
  endtask

  function automatic word_t ref_read(input bit sel3, input logic [4:0] a,
                                     input logic w, input logic [4:0] wa, input word_t wd);
    if (a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (w && wa == a) return wd;
`endif
    return sel3 ? mem3[a] : mem2[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem2[i] = '0;
      mem3[i] = '0;
    end
    last2[0] = '0; last2[1] = '0;
    last3[0] = '0; last3[1] = '0; last3[2] = '0;
  endtask

  task automatic step2(input logic rst, input logic w, input logic [4:0] wa, input word_t wd,
                       input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1);
    logic [1:0] ev;
    logic [4:0] ra [2];
    word_t d;
    ra[0] = a0; ra[1] = a1;
    reset = rst;
    bus2.we = w; bus2.waddr = wa; bus2.wdata = wd; bus2.re = r; bus2.raddr = {a1, a0};
    bus3.we = 1'b0; bus3.re = '0;
    ev = rst ? 2'b00 : r;
    for (int i = 0; i < 2; i++)
      if (ev[i]) sb_q.push_back(ref_read(1'b0, ra[i], w, wa, wd));
    if (rst) model_reset();
    else if (w && wa != 5'd0) mem2[wa] = wd;
    @(posedge clk); #1;
    check_eq("rvalid2", 96'(bus2.rvalid), 96'(ev));
    for (int i = 0; i < 2; i++) begin
      if (ev[i]) begin
        sb_pop(d);
        last2[i] = d;
      end
      check_eq($sformatf("rdata2[%0d]", i), 96'(bus2.rdata[i*DW +: DW]), 96'(last2[i]));
    end
  endtask

  task automatic step3(input logic rst, input logic w, input logic [4:0] wa, input word_t wd,
                       input logic [2:0] r, input logic [14:0] ra_pk);
    logic [2:0] ev;
    word_t d;
    reset = rst;
    bus3.we = w; bus3.waddr = wa; bus3.wdata = wd; bus3.re = r; bus3.raddr = ra_pk;
    bus2.we = 1'b0; bus2.re = '0;
    ev = rst ? 3'b000 : r;
    for (int i = 0; i < 3; i++)
      if (ev[i]) sb_q.push_back(ref_read(1'b1, ra_pk[i*5 +: 5], w, wa, wd));
    if (rst) model_reset();
    else if (w && wa != 5'd0) mem3[wa] = wd;
    @(posedge clk); #1;
    check_eq("rvalid3", 96'(bus3.rvalid), 96'(ev));
    for (int i = 0; i < 3; i++) begin
      if (ev[i]) begin
        sb_pop(d);
        last3[i] = d;
      end
      check_eq($sformatf("rdata3[%0d]", i), 96'(bus3.rdata[i*DW +: DW]), 96'(last3[i]));
    end
    // Keep the 2-port instance's held outputs honest across these cycles too.
    if (rst) begin
      check_eq("rdata2_rst", 96'(bus2.rdata), 96'd0);
    end
  endtask

  initial begin
    model_reset();
    bus2.we = 1'b0; bus2.waddr = '0; bus2.wdata = '0; bus2.re = '0; bus2.raddr = '0;
    bus3.we = 1'b0; bus3.waddr = '0; bus3.wdata = '0; bus3.re = '0; bus3.raddr = '0;
    reset = 1'b1;

    // Reset, then read r0/r1 on both ports.
    step2(1'b1, 1'b0, 5'd0, '0, 2'b00, 5'd0, 5'd0);
    step2(1'b1, 1'b0, 5'd0, '0, 2'b00, 5'd0, 5'd0);
    step2(1'b0, 1'b0, 5'd0, '0, 2'b11, 5'd0, 5'd1);

    // r7 write, port 1 read only.
    step2(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0);
    step2(1'b0, 1'b0, 5'd0, '0, 2'b10, 5'd0, 5'd7);
    step2(1'b0, 1'b0, 5'd0, '0, 2'b00, 5'd0, 5'd0);

    // r0 is hardwired to zero, including a same-cycle write/read.
    step2(1'b0, 1'b1, 5'd0, 32'h12345678, 2'b00, 5'd0, 5'd0);
    step2(1'b0, 1'b0, 5'd0, '0, 2'b11, 5'd0, 5'd0);
    step2(1'b0, 1'b1, 5'd0, 32'hCAFEF00D, 2'b01, 5'd0, 5'd0);

    // Read-during-write on r5 from both ports, then a plain read.
    step2(1'b0, 1'b1, 5'd5, 32'h11111111, 2'b00, 5'd0, 5'd0);
    step2(1'b0, 1'b1, 5'd5, 32'h22222222, 2'b11, 5'd5, 5'd5);
    step2(1'b0, 1'b0, 5'd0, '0, 2'b01, 5'd5, 5'd0);

    // Reset wins over a write and a read in the same cycle.
    step2(1'b0, 1'b1, 5'd4, 32'h0BADC0DE, 2'b00, 5'd0, 5'd0);
    step2(1'b1, 1'b1, 5'd3, 32'hAAAA5555, 2'b11, 5'd4, 5'd7);
    step2(1'b0, 1'b0, 5'd0, '0, 2'b11, 5'd3, 5'd4);

    // Randomised traffic with frequent address collisions.
    for (int n = 0; n < 80; n++) begin
      logic [4:0] wa, a0, a1;
      wa = 5'($urandom_range(0, 31));
      a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? a0 : 5'($urandom_range(0, 31));
      step2(1'b0, 1'($urandom_range(0, 1)), wa, word_t'($urandom()),
            2'($urandom_range(0, 3)), a0, a1);
    end

    // Three-port instance: all ports on r9 in one cycle.
    step3(1'b1, 1'b0, 5'd0, '0, 3'b000, '0);
    step3(1'b0, 1'b1, 5'd9, 32'h0000ABCD, 3'b000, '0);
    step3(1'b0, 1'b0, 5'd0, '0, 3'b111, {5'd9, 5'd9, 5'd9});
    step3(1'b0, 1'b1, 5'd9, 32'h00005A5A, 3'b101, {5'd9, 5'd2, 5'd9});
    step3(1'b0, 1'b0, 5'd0, '0, 3'b010, {5'd0, 5'd9, 5'd0});

    check_eq("sb_drained", 96'(sb_q.size()), 96'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register and port data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width; register count is 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of independent read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, the synchronous active-high reset.
REQ-008 SHALL have port we, input, 1 bit, the write enable.
REQ-009 SHALL have port waddr, input, ADDR_W bits, the write address.
REQ-010 SHALL have port wdata, input, DATA_W bits, the write data.
REQ-011 SHALL have port re, input, NUM_RD bits, the per-port read request; bit i belongs to port i.
REQ-012 SHALL have port raddr, input, NUM_RD*ADDR_W bits, the packed read addresses; port i uses slice [i*ADDR_W +: ADDR_W].
REQ-013 SHALL have port rdata, output, NUM_RD*DATA_W bits, the packed registered read data; port i uses slice [i*DATA_W +: DATA_W].
REQ-014 SHALL have port rvalid, output, NUM_RD bits, the per-port read-data-valid flag.

Function
REQ-015 SHALL write wdata into register waddr on a rising edge when we=1 and reset=0.
REQ-016 SHALL ignore writes to address 0 when ZERO_REG=1, and SHALL always return 0 on reads of address 0.
REQ-017 SHALL have a read latency of exactly one cycle: re[i]=1 in cycle t gives rdata slice i and rvalid[i]=1 in cycle t+1.
REQ-018 SHALL drive rvalid[i]=0 and hold the previous rdata slice i in any cycle following re[i]=0.
REQ-019 SHALL serve all ports independently and concurrently, including several ports reading the same address in one cycle.
REQ-020 SHALL return the pre-write value on a read from the address being written in the same cycle, unless REGFILE_BYPASS_EN is defined.
REQ-021 SHALL return the newly written value from every later read, one cycle after the write edge.
REQ-022 SHALL accept a write and any number of reads in one cycle with no stall and no backpressure.

Reset
REQ-023 SHALL clear every register, every rdata slice and every rvalid bit to 0 on a rising edge with reset=1.
REQ-024 SHALL give reset priority over a write or read in the same cycle; that write is dropped and that read returns nothing (rvalid=0).
REQ-025 SHALL resume normal operation in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL, with macro REGFILE_BYPASS_EN defined, forward wdata to any port whose re=1 and raddr==waddr while we=1, so that port sees the new value at t+1.
REQ-027 SHALL, with REGFILE_BYPASS_EN defined, still return 0 for address 0 when ZERO_REG=1, with no forwarding.
REQ-028 SHALL, without REGFILE_BYPASS_EN, behave exactly as REQ-020, with no forwarding logic present.

Structure
REQ-029 SHALL take the default widths (DATA_W, ADDR_W, NUM_RD) and a data-word typedef from a shared package, regfile_pkg.
REQ-030 SHALL build each read port from one instance of sub-module regfile_read_mux, a parametrised 2**ADDR_W-to-1 combinational selector.
REQ-031 SHALL keep all sequential state (registers, rdata, rvalid) in regfile_mp itself.

Verification
REQ-032 SHALL cover: reset, then re=2'b11 and raddr=0,1 -> rdata=0,0 and rvalid=2'b11 one cycle later.
REQ-033 SHALL cover: write 0xDEADBEEF to r7, then port 1 reads r7 -> rdata[1]=0xDEADBEEF at t+1, and rvalid[0]=0 while re[0]=0.
REQ-034 SHALL cover: write 0x12345678 to r0 with ZERO_REG=1, then read r0 -> 0x00000000.
REQ-035 SHALL cover: r5=0x11111111, then write 0x22222222 to r5 while reading r5 in the same cycle -> 0x11111111 without the macro and 0x22222222 with REGFILE_BYPASS_EN.
REQ-036 SHALL cover: reset and we=1 (r3, 0xAAAA5555) in the same cycle, then read r3 -> 0x00000000.
REQ-037 SHALL cover: NUM_RD=3, all ports reading r9=0x0000ABCD in one cycle -> all three slices 0x0000ABCD and rvalid=3'b111.
